// File: rtl/instr_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit_pkg
// Shared definitions for the instruction fetch unit:
//   - fetch_state_e        : fetch FSM state encoding
//   - IFU_NOP              : instruction presented after reset (addi x0,x0,0)
//   - IFU_DEFAULT_RESET_PC : default first fetch address
//   - ifu_clear_bit0       : JALR target alignment helper
// ---------------------------------------------------------------------------
package instr_fetch_unit_pkg;

  typedef enum logic [2:0] {
    FS_IDLE  = 3'd0,
    FS_REQ   = 3'd1,
    FS_WAIT  = 3'd2,
    FS_VALID = 3'd3,
    FS_ERR   = 3'd4
  } fetch_state_e;

  localparam logic [31:0] IFU_NOP              = 32'h0000_0013;
  localparam logic [31:0] IFU_DEFAULT_RESET_PC = 32'h0000_0000;

  // JALR targets discard bit 0 of rs1+imm.
  function automatic logic [31:0] ifu_clear_bit0(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFE;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_next_pc_gen.sv
// ---------------------------------------------------------------------------
// next_pc_gen
// Combinational next-PC selection for the fetch unit.
// Ports:
//   pc         in  32  PC of the instruction being consumed
//   imm_ext    in  32  sign-extended immediate (branch / JAL offset)
//   alu_result in  32  rs1+imm (JALR target before alignment)
//   bbranch    in  1   conditional branch
//   jbranch    in  1   JAL
//   jibranch   in  1   JALR (highest priority)
//   btaken     in  1   branch comparison true
//   next_pc    out 32  selected next PC (wraps modulo 2^32)
//   misaligned out 1   next_pc is not 4-byte aligned (bit 1 set)
// ---------------------------------------------------------------------------
module next_pc_gen
  import instr_fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] imm_ext,
  input  logic [31:0] alu_result,
  input  logic        bbranch,
  input  logic        jbranch,
  input  logic        jibranch,
  input  logic        btaken,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  // Priority select: JALR, then JAL / taken branch, then sequential.
  always_comb begin
    next_pc = pc + 32'd4;
    if (jibranch) begin
      next_pc = ifu_clear_bit0(alu_result);
    end else if (jbranch || (bbranch && btaken)) begin
      next_pc = pc + imm_ext;
    end else begin
      next_pc = pc + 32'd4;
    end
  end

  // Bit 0 is always clear here for JALR; bit 1 flags a half-word target.
  assign misaligned = next_pc[1];

endmodule

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Multi-cycle instruction fetch: request a word, wait for the response,
// hold it for the decoder until consumed, then advance the PC.
// Ports:
//   clk, reset                       clock, async active-high reset
//   imem_req/imem_addr               fetch strobe and byte address (= PC)
//   imem_rdata/imem_rvalid           instruction memory response
//   instr_code/instr_valid           held instruction for the decoder
//   decode_ready                     decoder consumes instr_code this cycle
//   Bbranch/Jbranch/JIbranch/btaken  branch controls (sampled on consume)
//   imm_ext/alu_result               branch / JALR target operands
//   pc_out/pc_plus4                  PC of instr_code and its link value
//   retired_cnt                      consumed-instruction count (wraps)
//   fetch_err                        sticky misaligned-target fault
// ---------------------------------------------------------------------------
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  output logic [31:0] instr_code,
  output logic        instr_valid,
  input  logic        decode_ready,
  input  logic        Bbranch,
  input  logic        Jbranch,
  input  logic        JIbranch,
  input  logic        btaken,
  input  logic [31:0] imm_ext,
  input  logic [31:0] alu_result,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic [31:0] retired_cnt,
  output logic        fetch_err
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_code_q, instr_code_d;
  logic [31:0]  retired_cnt_q, retired_cnt_d;
  logic         imem_req_q, imem_req_d;
  logic         instr_valid_q, instr_valid_d;
  logic         fetch_err_q, fetch_err_d;
  logic [31:0]  next_pc_s;
  logic         misaligned_s;

  next_pc_gen u_next_pc_gen (
    .pc         (pc_q),
    .imm_ext    (imm_ext),
    .alu_result (alu_result),
    .bbranch    (Bbranch),
    .jbranch    (Jbranch),
    .jibranch   (JIbranch),
    .btaken     (btaken),
    .next_pc    (next_pc_s),
    .misaligned (misaligned_s)
  );

  // Fetch FSM next-state and datapath updates.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_code_d  = instr_code_q;
    retired_cnt_d = retired_cnt_q;
    case (state_q)
      FS_IDLE: state_d = FS_REQ;
      // Any response seen while requesting is ignored: only WAIT captures.
      FS_REQ:  state_d = FS_WAIT;
      FS_WAIT: begin
        if (imem_rvalid) begin
          instr_code_d = imem_rdata;
          state_d      = FS_VALID;
        end else begin
          state_d = FS_WAIT;
        end
      end
      FS_VALID: begin
        if (decode_ready) begin
          // The consumed instruction retires even if its target faults.
          retired_cnt_d = retired_cnt_q + 32'd1;
          if (misaligned_s) begin
            state_d = FS_ERR;
          end else begin
            pc_d    = next_pc_s;
            state_d = FS_REQ;
          end
        end else begin
          state_d = FS_VALID;
        end
      end
      FS_ERR:  state_d = FS_ERR;
      default: state_d = FS_IDLE;
    endcase
    // Strobes are registered so they line up with the state they describe.
    imem_req_d    = (state_d == FS_REQ);
    instr_valid_d = (state_d == FS_VALID);
    fetch_err_d   = (state_d == FS_ERR);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= FS_IDLE;
      pc_q          <= RESET_PC;
      instr_code_q  <= IFU_NOP;
      retired_cnt_q <= 32'd0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_code_q  <= instr_code_d;
      retired_cnt_q <= retired_cnt_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
      fetch_err_q   <= fetch_err_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign instr_code  = instr_code_q;
  assign instr_valid = instr_valid_q;
  assign pc_out      = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign retired_cnt = retired_cnt_q;
  assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
// Directed + randomized bench for instr_fetch_unit. A small reference model
// tracks the architectural PC, retired count and the held instruction word;
// the bench acts as instruction memory and as the decoder.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_rvalid;
  logic [31:0] instr_code;
  logic        instr_valid;
  logic        decode_ready;
  logic        Bbranch;
  logic        Jbranch;
  logic        JIbranch;
  logic        btaken;
  logic [31:0] imm_ext;
  logic [31:0] alu_result;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic [31:0] retired_cnt;
  logic        fetch_err;

  instr_fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_rvalid  (imem_rvalid),
    .instr_code   (instr_code),
    .instr_valid  (instr_valid),
    .decode_ready (decode_ready),
    .Bbranch      (Bbranch),
    .Jbranch      (Jbranch),
    .JIbranch     (JIbranch),
    .btaken       (btaken),
    .imm_ext      (imm_ext),
    .alu_result   (alu_result),
    .pc_out       (pc_out),
    .pc_plus4     (pc_plus4),
    .retired_cnt  (retired_cnt),
    .fetch_err    (fetch_err)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic [31:0] m_instr;
  logic        m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic junk_controls();
    Bbranch    = 1'($urandom);
    Jbranch    = 1'($urandom);
    JIbranch   = 1'($urandom);
    btaken     = 1'($urandom);
    imm_ext    = $urandom;
    alu_result = $urandom;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    imem_rvalid  = 1'b0;
    imem_rdata   = 32'd0;
    decode_ready = 1'b0;
    junk_controls();
    repeat (2) @(negedge clk);
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
    chk("rst_instr_code", instr_code, 32'h0000_0013);
    chk("rst_retired", retired_cnt, 32'd0);
    chk("rst_imem_addr", imem_addr, 32'd0);
    reset   = 1'b0;
    m_pc    = 32'd0;
    m_cnt   = 32'd0;
    m_instr = 32'h0000_0013;
    m_err   = 1'b0;
  endtask

  // Act as memory for one fetch: find the request, answer after 'delay'
  // wait cycles, then check the word is presented to the decoder.
  task automatic fetch(input logic [31:0] data, input int delay);
    int waited = 0;
    while (imem_req !== 1'b1 && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    chk("req_seen", {31'd0, imem_req}, 32'd1);
    chk("req_addr", imem_addr, m_pc);
    // A stray response during the request cycle must be dropped.
    imem_rvalid = 1'($urandom);
    imem_rdata  = $urandom;
    @(negedge clk);
    imem_rvalid = 1'b0;
    for (int i = 0; i < delay; i++) begin
      chk("wait_no_req", {31'd0, imem_req}, 32'd0);
      chk("wait_no_valid", {31'd0, instr_valid}, 32'd0);
      @(negedge clk);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    m_instr     = data;
    chk("valid", {31'd0, instr_valid}, 32'd1);
    chk("instr_code", instr_code, m_instr);
    chk("pc_out", pc_out, m_pc);
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("retired_hold", retired_cnt, m_cnt);
  endtask

  // Act as the decoder: stall, then consume with the given controls.
  task automatic consume(input logic bb, input logic jb, input logic jib, input logic bt,
                         input logic [31:0] imm, input logic [31:0] alu, input int stall);
    logic [31:0] target;
    for (int i = 0; i < stall; i++) begin
      decode_ready = 1'b0;
      junk_controls();
      @(negedge clk);
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_code", instr_code, m_instr);
      chk("stall_pc", pc_out, m_pc);
      chk("stall_no_req", {31'd0, imem_req}, 32'd0);
      chk("stall_retired", retired_cnt, m_cnt);
    end
    Bbranch = bb; Jbranch = jb; JIbranch = jib; btaken = bt;
    imm_ext = imm; alu_result = alu;
    decode_ready = 1'b1;
    if (jib)                  target = {alu[31:1], 1'b0};
    else if (jb || (bb && bt)) target = m_pc + imm;
    else                       target = m_pc + 32'd4;
    @(negedge clk);
    decode_ready = 1'b0;
    junk_controls();
    m_cnt = m_cnt + 32'd1;
    if (target[1]) begin
      m_err = 1'b1;
      chk("err_flag", {31'd0, fetch_err}, 32'd1);
      chk("err_no_valid", {31'd0, instr_valid}, 32'd0);
      chk("err_no_req", {31'd0, imem_req}, 32'd0);
      chk("err_pc_kept", imem_addr, m_pc);
    end else begin
      m_pc = target;
      chk("consume_req_next", {31'd0, imem_req}, 32'd1);
      chk("consume_addr", imem_addr, m_pc);
      chk("consume_no_err", {31'd0, fetch_err}, 32'd0);
    end
    chk("retired", retired_cnt, m_cnt);
  endtask

  task automatic jump_to(input logic [31:0] addr);
    fetch($urandom, 0);
    consume(1'b0, 1'b0, 1'b1, 1'b0, $urandom, addr, 0);
  endtask

  initial begin
    clk = 1'b0;
    do_reset();

    // Sequential fetch from reset at zero wait.
    for (int i = 0; i < 3; i++) begin
      fetch($urandom, 0);
      consume(1'b0, 1'b0, 1'b0, 1'b0, $urandom & 32'hFFFF_FFFC, $urandom, 0);
    end
    chk("three_retired", retired_cnt, 32'd3);
    chk("seq_addr_0xC", imem_addr, 32'h0000_000C);

    // Randomized traffic; targets kept word-aligned.
    for (int i = 0; i < 25; i++) begin
      fetch($urandom, $urandom_range(0, 3));
      consume(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFD,
              $urandom_range(0, 2));
    end

    // Taken / not-taken backward branch at 0x100.
    jump_to(32'h0000_0100);
    fetch($urandom, 1);
    consume(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF0, $urandom, 0);
    chk("btaken_addr", imem_addr, 32'h0000_00F0);
    jump_to(32'h0000_0100);
    fetch($urandom, 0);
    consume(1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF0, $urandom, 0);
    chk("bnottaken_addr", imem_addr, 32'h0000_0104);

    // JALR beats JAL and drops bit 0.
    jump_to(32'h0000_0200);
    fetch($urandom, 0);
    chk("jalr_link", pc_plus4, 32'h0000_0204);
    consume(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0000_0305, 0);
    chk("jalr_addr", imem_addr, 32'h0000_0304);

    // Long decoder stall.
    fetch($urandom, 2);
    consume(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5);

    // PC wraps at the top of the address space.
    jump_to(32'hFFFF_FFFC);
    fetch($urandom, 0);
    consume(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 0);
    chk("pc_wrap", imem_addr, 32'h0000_0000);

    // Misaligned JAL target faults and sticks.
    jump_to(32'h0000_0010);
    fetch($urandom, 0);
    consume(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0006, 32'd0, 0);
    for (int i = 0; i < 5; i++) begin
      imem_rvalid  = 1'($urandom);
      decode_ready = 1'($urandom);
      @(negedge clk);
      chk("err_sticky", {31'd0, fetch_err}, 32'd1);
      chk("err_idle_req", {31'd0, imem_req}, 32'd0);
      chk("err_idle_valid", {31'd0, instr_valid}, 32'd0);
      chk("err_pc_0x10", imem_addr, 32'h0000_0010);
      chk("err_retired", retired_cnt, m_cnt);
    end
    imem_rvalid  = 1'b0;
    decode_ready = 1'b0;

    // Reset during WAIT discards the outstanding response.
    do_reset();
    fetch($urandom, 0);
    consume(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_pc = 32'd0; m_cnt = 32'd0; m_instr = 32'h0000_0013;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("rst_wait_req", {31'd0, imem_req}, 32'd1);
    chk("rst_wait_addr", imem_addr, 32'h0000_0000);
    chk("rst_wait_retired", retired_cnt, 32'd0);
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk("rst_wait_code_nop", instr_code, 32'h0000_0013);
    chk("rst_wait_no_valid", {31'd0, instr_valid}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1234_5678;
    @(negedge clk);
    imem_rvalid = 1'b0;
    m_instr = 32'h1234_5678;
    chk("restart_valid", {31'd0, instr_valid}, 32'd1);
    chk("restart_code", instr_code, m_instr);
    consume(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 0);
    chk("restart_next_addr", imem_addr, 32'h0000_0004);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
